// File: rtl/pipe_out_source.sv
// pipe_out_source
// Producer stage for a BTPipeOut endpoint. It generates either a 32-bit LFSR
// stream or a 16-bit counter stream. A rotating write-enable pattern throttles
// the stream into an internal FIFO. The host sees a registered block-ready flag,
// and each popped word appears one cycle after its read strobe. Reads that arrive
// while the FIFO is empty are counted in a saturating underflow counter.
module pipe_out_source #(
    parameter int BLOCK_WORDS = 256,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              throttle_set,
    input  logic [31:0]       throttle_val,
    input  logic              pipe_out_read,
    output logic [15:0]       pipe_out_data,
    output logic              pipe_out_ready,
    output logic [ADDR_W:0]   fill_count,
    output logic [15:0]       underflow_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] READY_LEVEL = (ADDR_W+1)'(BLOCK_WORDS);

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [31:0]       lfsr;
    logic [15:0]       counter;
    logic [31:0]       throttle;

    logic              wr_en;
    logic              rd_en;
    logic              read_empty;
    logic [15:0]       wr_word;
    logic [31:0]       lfsr_next;

    // Decode this cycle's write/read qualification and the word to be written.
    // A full FIFO blocks the write, so neither generator advances while full.
    always_comb begin
        wr_en      = !throttle_set && throttle[0] && (fill_count != FULL_LEVEL);
        rd_en      = pipe_out_read && (fill_count != '0);
        read_empty = pipe_out_read && (fill_count == '0);
        wr_word    = mode ? counter : lfsr[15:0];
        lfsr_next  = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    end

    // Storage array. It has no reset so it can map onto block RAM; a read of the
    // address being written in the same cycle returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Generators and throttle pattern. Only the selected generator steps on a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr     <= 32'h0000_0001;
            counter  <= 16'h0000;
            throttle <= 32'hFFFF_FFFF;
        end else begin
            if (throttle_set) begin
                throttle <= throttle_val;
            end else begin
                throttle <= {throttle[0], throttle[31:1]};
            end
            if (wr_en) begin
                if (mode) begin
                    counter <= counter + 16'd1;
                end else begin
                    lfsr <= lfsr_next;
                end
            end
        end
    end

    // FIFO pointers, occupancy, read data register and registered ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill_count     <= '0;
            pipe_out_data  <= 16'h0000;
            pipe_out_ready <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                pipe_out_data <= mem[rd_ptr];
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   fill_count <= fill_count + 1'b1;
                2'b01:   fill_count <= fill_count - 1'b1;
                default: fill_count <= fill_count;
            endcase
            pipe_out_ready <= (fill_count >= READY_LEVEL);
        end
    end

    // Saturating count of reads that found the FIFO empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow_count <= 16'h0000;
        end else if (read_empty && (underflow_count != 16'hFFFF)) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end

endmodule
